// File: rtl/conv_row_mac.sv
// rtl/conv_row_mac.sv - parametrised KxK row-streamed convolution MAC with channel accumulation
//
// Purpose: consumes one K-pixel row per accepted beat, multiplies it by the
// matching kernel row, sums K rows into a window, accumulates windows across
// input channels and emits one biased, optionally ReLU'd result per pixel.
//
// Ports:
//   clk       clock
//   rst       synchronous reset, active-high
//   in_valid  beat qualifier
//   data_in   K pixels, pixel c at [(K-1-c)*DW +: DW]
//   w_in      KxK weights, w(r,c) at [(K*K-1-(r*K+c))*DW +: DW]
//   mirror    horizontal kernel flip
//   last_ch   final input channel marker (row K-1 beat only)
//   bias      added to channel sum on the final channel
//   relu_en   clamp negative results to zero
//   clr       synchronous abort of in-flight work
//   out_valid one-cycle result strobe
//   ans_out   signed result, held between strobes
module conv_row_mac #(
  parameter int DW   = 8,
  parameter int K    = 3,
  parameter int ACCW = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [K*DW-1:0]        data_in,
  input  logic [K*K*DW-1:0]      w_in,
  input  logic                   mirror,
  input  logic                   last_ch,
  input  logic [ACCW-1:0]        bias,
  input  logic                   relu_en,
  input  logic                   clr,
  output logic                   out_valid,
  output logic [ACCW-1:0]        ans_out
);

  localparam int ROWW = (K > 1) ? $clog2(K) : 1;
  localparam logic [ROWW-1:0] LAST_ROW = ROWW'(K - 1);

  logic [ROWW-1:0] row;
  logic            accept;

  logic                   s1_valid;
  logic [ROWW-1:0]        s1_row;
  logic signed [ACCW-1:0] s1_sum;
  logic                   s1_last;
  logic [ACCW-1:0]        s1_bias;
  logic                   s1_relu;

  logic signed [ACCW-1:0] win_acc;
  logic signed [ACCW-1:0] ch_acc;
  logic                   p_valid;
  logic [ACCW-1:0]        p_res;

  logic signed [ACCW-1:0] row_sum;
  logic signed [ACCW-1:0] win_sum;
  logic signed [ACCW-1:0] total;
  logic [ACCW-1:0]        result;

  assign accept = in_valid & ~clr;

  // Row dot product: the current row counter selects the kernel row.
  always_comb begin
    logic signed [DW-1:0]   pix;
    logic signed [DW-1:0]   wt;
    logic signed [2*DW-1:0] prod;
    int                     widx;
    int                     wbase;
    row_sum = '0;
    pix     = '0;
    wt      = '0;
    prod    = '0;
    widx    = 0;
    wbase   = 0;
    for (int c = 0; c < K; c++) begin
      pix   = $signed(data_in[(K-1-c)*DW +: DW]);
      widx  = mirror ? (K - 1 - c) : c;
      wbase = (K*K - 1 - (int'(row)*K + widx)) * DW;
      wt    = $signed(w_in[wbase +: DW]);
      prod  = pix * wt;
      // Size cast of a signed product sign-extends to the accumulator width.
      row_sum = row_sum + ACCW'(prod);
    end
  end

  // Row 0 restarts the window so no stale partial sum carries over.
  assign win_sum = (s1_row == '0) ? s1_sum : (win_acc + s1_sum);
  assign total   = ch_acc + win_sum + $signed(s1_bias);
  assign result  = (s1_relu && total[ACCW-1]) ? '0 : total;

  always_ff @(posedge clk) begin
    if (rst) begin
      row       <= '0;
      s1_valid  <= 1'b0;
      s1_row    <= '0;
      s1_sum    <= '0;
      s1_last   <= 1'b0;
      s1_bias   <= '0;
      s1_relu   <= 1'b0;
      win_acc   <= '0;
      ch_acc    <= '0;
      p_valid   <= 1'b0;
      p_res     <= '0;
      out_valid <= 1'b0;
      ans_out   <= '0;
    end else if (clr) begin
      // Abort everything in flight but keep the last delivered result.
      row       <= '0;
      s1_valid  <= 1'b0;
      win_acc   <= '0;
      ch_acc    <= '0;
      p_valid   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      // Stage 1
      s1_valid <= accept;
      if (accept) begin
        row     <= (row == LAST_ROW) ? '0 : row + ROWW'(1);
        s1_row  <= row;
        s1_sum  <= row_sum;
        s1_last <= last_ch;
        s1_bias <= bias;
        s1_relu <= relu_en;
      end

      // Stage 2
      p_valid <= 1'b0;
      if (s1_valid) begin
        if (s1_row == LAST_ROW) begin
          win_acc <= '0;
          if (s1_last) begin
            p_res   <= result;
            p_valid <= 1'b1;
            ch_acc  <= '0;
          end else begin
            ch_acc  <= ch_acc + win_sum;
          end
        end else begin
          win_acc <= win_sum;
        end
      end

      // Output register
      out_valid <= p_valid;
      if (p_valid) begin
        ans_out <= p_res;
      end
    end
  end

endmodule

// File: tb/tb_conv_row_mac.sv
// tb/tb_conv_row_mac.sv - directed self-checking bench for conv_row_mac
module tb_conv_row_mac;

  localparam int DW   = 8;
  localparam int K    = 3;
  localparam int ACCW = 32;
  localparam int N    = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [K*DW-1:0]   data_in = '0;
  logic [K*K*DW-1:0] w_in = '0;
  logic              mirror = 1'b0;
  logic              last_ch = 1'b0;
  logic [ACCW-1:0]   bias = '0;
  logic              relu_en = 1'b0;
  logic              clr = 1'b0;
  logic              out_valid;
  logic [ACCW-1:0]   ans_out;

  int checks = 0;
  int failures = 0;

  // Per-cycle stimulus and recorded outputs (state after the posedge of that cycle).
  logic              sv [N];
  logic              sl [N];
  logic              sc [N];
  logic              sr [N];
  logic              rec_ov [N];
  logic [ACCW-1:0]   rec_ans [N];

  conv_row_mac #(.DW(DW), .K(K), .ACCW(ACCW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .data_in   (data_in),
    .w_in      (w_in),
    .mirror    (mirror),
    .last_ch   (last_ch),
    .bias      (bias),
    .relu_en   (relu_en),
    .clr       (clr),
    .out_valid (out_valid),
    .ans_out   (ans_out)
  );

  always #5 clk = ~clk;

  task automatic std_data();
    data_in = {8'd1, 8'd2, 8'd3};
    w_in    = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
  endtask

  task automatic clear_seq();
    for (int i = 0; i < N; i++) begin
      sv[i] = 1'b0; sl[i] = 1'b0; sc[i] = 1'b0; sr[i] = 1'b0;
    end
  endtask

  // Drives n cycles from the tables, starting and ending on a negedge.
  task automatic play(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = sv[i];
      last_ch  = sl[i];
      clr      = sc[i];
      rst      = sr[i];
      @(negedge clk);
      rec_ov[i]  = out_valid;
      rec_ans[i] = ans_out;
    end
    in_valid = 1'b0; last_ch = 1'b0; clr = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (ans_out !== 32'd0) begin
      failures++; $display("FAIL reset_ans got=%0d exp=0", $signed(ans_out));
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic exp;
    clear_seq();
    std_data(); mirror = 1'b0; bias = '0; relu_en = 1'b0;
    sv[0] = 1; sv[1] = 1; sv[2] = 1; sl[2] = 1;
    play(8);
    for (int i = 0; i < 8; i++) begin
      exp = (i == 4);
      checks++;
      if (rec_ov[i] !== exp) begin
        failures++; $display("FAIL single_pulse cyc=%0d got=%b exp=%b", i, rec_ov[i], exp);
      end
    end
    checks++;
    if (rec_ans[4] !== 32'd96) begin
      failures++; $display("FAIL single_ans got=%0d exp=96", $signed(rec_ans[4]));
    end
  endtask

  task automatic test_mirror();
    logic exp;
    clear_seq();
    std_data(); mirror = 1'b1; bias = '0; relu_en = 1'b0;
    sv[0] = 1; sv[1] = 1; sv[2] = 1; sl[2] = 1;
    play(8);
    for (int i = 0; i < 8; i++) begin
      exp = (i == 4);
      checks++;
      if (rec_ov[i] !== exp) begin
        failures++; $display("FAIL mirror_pulse cyc=%0d got=%b exp=%b", i, rec_ov[i], exp);
      end
    end
    checks++;
    if (rec_ans[4] !== 32'd84) begin
      failures++; $display("FAIL mirror_ans got=%0d exp=84", $signed(rec_ans[4]));
    end
    mirror = 1'b0;
  endtask

  task automatic test_clr();
    logic exp;
    clear_seq();
    std_data(); mirror = 1'b0; bias = '0; relu_en = 1'b0;
    sv[0] = 1; sv[1] = 1; sl[0] = 1; sl[1] = 1;
    sv[2] = 1; sl[2] = 1; sc[2] = 1;
    sv[3] = 1; sv[4] = 1; sv[5] = 1; sl[5] = 1;
    play(10);
    for (int i = 0; i < 10; i++) begin
      exp = (i == 7);
      checks++;
      if (rec_ov[i] !== exp) begin
        failures++; $display("FAIL clr_pulse cyc=%0d got=%b exp=%b", i, rec_ov[i], exp);
      end
    end
    for (int i = 2; i < 7; i++) begin
      checks++;
      if (rec_ans[i] !== 32'd84) begin
        failures++; $display("FAIL clr_hold cyc=%0d got=%0d exp=84", i, $signed(rec_ans[i]));
      end
    end
    checks++;
    if (rec_ans[7] !== 32'd96) begin
      failures++; $display("FAIL clr_ans got=%0d exp=96", $signed(rec_ans[7]));
    end
  endtask

  task automatic test_extreme();
    clear_seq();
    data_in = {K{8'h80}};
    w_in    = {(K*K){8'h7F}};
    mirror = 1'b0; bias = '0; relu_en = 1'b0;
    sv[0] = 1; sv[1] = 1; sv[2] = 1; sl[2] = 1;
    play(6);
    checks++;
    if (rec_ov[4] !== 1'b1 || rec_ans[4] !== 32'hFFFDC480) begin
      failures++; $display("FAIL extreme_neg got=%b/%0d exp=1/-146304", rec_ov[4], $signed(rec_ans[4]));
    end
    relu_en = 1'b1;
    play(6);
    checks++;
    if (rec_ov[4] !== 1'b1 || rec_ans[4] !== 32'd0) begin
      failures++; $display("FAIL extreme_relu got=%b/%0d exp=1/0", rec_ov[4], $signed(rec_ans[4]));
    end
    relu_en = 1'b0;
    std_data();
  endtask

  task automatic test_channels();
    logic exp;
    clear_seq();
    std_data(); mirror = 1'b0; bias = 32'd4; relu_en = 1'b0;
    for (int i = 0; i < 6; i++) sv[i] = 1;
    // last_ch on non-final rows must be ignored.
    sl[0] = 1; sl[1] = 1; sl[2] = 0; sl[3] = 0; sl[4] = 0; sl[5] = 1;
    play(10);
    for (int i = 0; i < 10; i++) begin
      exp = (i == 7);
      checks++;
      if (rec_ov[i] !== exp) begin
        failures++; $display("FAIL chan_pulse cyc=%0d got=%b exp=%b", i, rec_ov[i], exp);
      end
    end
    checks++;
    if (rec_ans[7] !== 32'd196) begin
      failures++; $display("FAIL chan_ans got=%0d exp=196", $signed(rec_ans[7]));
    end
    bias = '0;
  endtask

  task automatic test_idle();
    logic exp;
    clear_seq();
    std_data(); mirror = 1'b0; bias = '0; relu_en = 1'b0;
    sv[0] = 1; sv[3] = 1; sv[6] = 1; sl[6] = 1;
    play(11);
    for (int i = 0; i < 11; i++) begin
      exp = (i == 8);
      checks++;
      if (rec_ov[i] !== exp) begin
        failures++; $display("FAIL idle_pulse cyc=%0d got=%b exp=%b", i, rec_ov[i], exp);
      end
    end
    checks++;
    if (rec_ans[8] !== 32'd96) begin
      failures++; $display("FAIL idle_ans got=%0d exp=96", $signed(rec_ans[8]));
    end
  endtask

  task automatic test_back_to_back();
    logic exp;
    clear_seq();
    std_data(); mirror = 1'b0; bias = '0; relu_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sv[i] = 1; sl[i] = 1;
    end
    play(10);
    for (int i = 0; i < 10; i++) begin
      exp = (i == 4) || (i == 7);
      checks++;
      if (rec_ov[i] !== exp) begin
        failures++; $display("FAIL b2b_pulse cyc=%0d got=%b exp=%b", i, rec_ov[i], exp);
      end
    end
    checks++;
    if (rec_ans[4] !== 32'd96 || rec_ans[7] !== 32'd96) begin
      failures++; $display("FAIL b2b_ans got=%0d,%0d exp=96,96", $signed(rec_ans[4]), $signed(rec_ans[7]));
    end
  endtask

  task automatic test_rst_mid();
    logic exp;
    clear_seq();
    std_data(); mirror = 1'b0; bias = '0; relu_en = 1'b0;
    sv[0] = 1; sv[1] = 1;
    sr[2] = 1;
    sv[3] = 1; sv[4] = 1; sv[5] = 1; sl[5] = 1;
    play(10);
    checks++;
    if (rec_ov[2] !== 1'b0 || rec_ans[2] !== 32'd0) begin
      failures++; $display("FAIL rstmid_clear got=%b/%0d exp=0/0", rec_ov[2], $signed(rec_ans[2]));
    end
    for (int i = 0; i < 10; i++) begin
      exp = (i == 7);
      checks++;
      if (rec_ov[i] !== exp) begin
        failures++; $display("FAIL rstmid_pulse cyc=%0d got=%b exp=%b", i, rec_ov[i], exp);
      end
    end
    checks++;
    if (rec_ans[7] !== 32'd96) begin
      failures++; $display("FAIL rstmid_ans got=%0d exp=96", $signed(rec_ans[7]));
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_mirror();
    test_clr();
    test_extreme();
    test_channels();
    test_idle();
    test_back_to_back();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_row_mac.md
Name: conv_row_mac

Overview:
- Parametrised K×K convolution MAC for the clipQ CNN datapath.
- Consumes one K-pixel image row per accepted beat and applies kernel row r to the r-th beat of a window. After K beats the window is complete.
- Accumulates completed windows across input channels, then emits one biased, optionally ReLU'd, result per output pixel.
- Adds three things to the fixed 3×3 calculator: parametrised size, a valid handshake, and channel accumulation with bias/ReLU.

Parameters:
- DW, 8, signed width of pixels and weights.
- K, 3, kernel size; the window is K beats of K pixels each.
- ACCW, 32, signed width of the accumulator, bias and output.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  beat qualifier.
- data_in  in  K*DW  pixel c at bits [(K-1-c)*DW +: DW].
- w_in  in  K*K*DW  weight (r,c) at bits [(K*K-1-(r*K+c))*DW +: DW], row-major, MSB first.
- mirror  in  1  1: kernel row r uses w(r,K-1-c) for pixel c (horizontal flip); 0: natural order.
- last_ch  in  1  marks the current window as the final input channel; sampled on the row-(K-1) beat.
- bias  in  ACCW  added to the channel sum; sampled on the row-(K-1) beat when last_ch=1.
- relu_en  in  1  clamp negative results to 0; sampled with bias.
- clr  in  1  synchronous abort: clears row counter, accumulators and in-flight stages.
- out_valid  out  1  one-cycle pulse when ans_out holds a new result.
- ans_out  out  ACCW  signed result.

Behaviour:
- Reset (rst=1 at posedge):
  - row counter=0; stage-1 and stage-2 valids=0; window and channel accumulators=0.
  - out_valid=0, ans_out=0.
  - rst mid-window discards all partial sums.
- No backpressure: a beat is accepted on every cycle with in_valid=1 and clr=0. Idle cycles between beats are allowed and do not alter state.
- Row counter: increments on each accepted beat and wraps from K-1 to 0. The weight row used for a beat equals its row index. w_in and mirror are sampled on every accepted beat.
- Stage 1 (registered on acceptance):
  - row_sum = Σ_c data_in[c]*w(r,c'), where c' is c or K-1-c per mirror.
  - Products are full 2*DW signed; the sum is sign-extended to ACCW.
  - Row index, last_ch, bias and relu_en are registered alongside.
- Stage 2 (registered when stage-1 valid):
  - win_acc += row_sum; for row 0, win_acc = row_sum (no stale carry-over).
  - On row K-1 with last_ch=0: ch_acc += completed window; win_acc is then free for the next window.
  - On row K-1 with last_ch=1:
    - result = ch_acc + completed window + bias; if relu_en and result<0, result=0.
    - Register result into ans_out and pulse out_valid.
    - Clear ch_acc in the same cycle.
- Latency: out_valid rises exactly 2 cycles after the posedge that accepts the row-(K-1) beat of the last channel.
- Back-to-back windows and channels run at full rate with no bubble. Consecutive output pixels may be spaced every K beats.
- Arithmetic: all adds are two's complement modulo 2^ACCW (wrap, no saturation).
- ans_out holds its value between pulses.
- clr=1:
  - Same effect as rst on the row counter, accumulators and stage valids.
  - ans_out keeps its last value; out_valid=0.
  - A beat presented in the same cycle as clr is discarded.
- last_ch is ignored on beats with row≠K-1.

Test Plan:
- K=3; data (1,2,3) on 3 beats; weights rows (1,2,3),(4,5,6),(7,8,9); mirror=0, last_ch=1, bias=0 -> one pulse, ans_out=96 (14+32+50), 2 cycles after the 3rd beat.
- Same stimulus with mirror=1 -> ans_out=84 (10+28+46).
- All pixels -128, all weights 127, last_ch=1:
  - relu_en=0 -> ans_out=-146304 (0xFFFDC480).
  - relu_en=1 -> ans_out=0.
- Two channels of the first stimulus (last_ch=0 then 1) with bias=4 -> single pulse, ans_out=196; no pulse after channel 0.
- First stimulus with 2 idle cycles between beats -> ans_out=96, latency still 2 cycles from the last beat. Then 2 full windows back-to-back -> two pulses 3 cycles apart, both 96.
- Assert clr after beat 2 of a window, then send a full window -> only 96 is emitted.
- Assert rst mid-window -> out_valid=0 and ans_out=0 next cycle; a following window yields 96.
